// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction stream encoder: mnemonic IDs, MIPS opcode/funct
// constants, FSM state encoding and small word-packing helpers.
package instr_enc_pkg;

  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND = 5'd2,  MN_OR   = 5'd3,
    MN_SLT  = 5'd4,  MN_JR   = 5'd5,  MN_ADDI = 5'd6, MN_SLTI = 5'd7,
    MN_ORI  = 5'd8,  MN_LUI  = 5'd9,  MN_LW  = 5'd10, MN_SW   = 5'd11,
    MN_BEQ  = 5'd12, MN_BNE  = 5'd13, MN_BLT = 5'd14, MN_BGEZ = 5'd15,
    MN_J    = 5'd16, MN_JAL  = 5'd17
  } mnem_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BGEZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLT   = 6'd6;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: mnemonic ID plus register/immediate/target fields into a 32-bit
// MIPS word, with a legal flag for unknown mnemonics.
module instr_field_packer
  import instr_enc_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (mnem_i)
      MN_ADD:  word_o = r_word(rs_i, rt_i, rd_i, FN_ADD);
      MN_SUB:  word_o = r_word(rs_i, rt_i, rd_i, FN_SUB);
      MN_AND:  word_o = r_word(rs_i, rt_i, rd_i, FN_AND);
      MN_OR:   word_o = r_word(rs_i, rt_i, rd_i, FN_OR);
      MN_SLT:  word_o = r_word(rs_i, rt_i, rd_i, FN_SLT);
      MN_JR:   word_o = r_word(rs_i, 5'd0, 5'd0, FN_JR);
      MN_ADDI: word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
      MN_SLTI: word_o = i_word(OP_SLTI, rs_i, rt_i, imm_i);
      MN_ORI:  word_o = i_word(OP_ORI,  rs_i, rt_i, imm_i);
      MN_LUI:  word_o = i_word(OP_LUI,  5'd0, rt_i, imm_i);
      MN_LW:   word_o = i_word(OP_LW,   rs_i, rt_i, imm_i);
      MN_SW:   word_o = i_word(OP_SW,   rs_i, rt_i, imm_i);
      MN_BEQ:  word_o = i_word(OP_BEQ,  rs_i, rt_i, imm_i);
      MN_BNE:  word_o = i_word(OP_BNE,  rs_i, rt_i, imm_i);
      MN_BLT:  word_o = i_word(OP_BLT,  rs_i, rt_i, imm_i);
      // BGEZ shares opcode 1 with the REGIMM group; rt=1 selects it
      MN_BGEZ: word_o = i_word(OP_BGEZ, rs_i, 5'd1, imm_i);
      MN_J:    word_o = j_word(OP_J,   target_i);
      MN_JAL:  word_o = j_word(OP_JAL, target_i);
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Session controller: accepts symbolic instructions, writes encoded words sequentially into
// instruction memory, keeps a word count, XOR checksum and sticky error flags.
//   state   | meaning
//   IDLE    | no session; fields not accepted
//   LOAD    | accepting fields, one memory write per accepted legal instruction
//   DONE    | final instruction accepted; done_o high for this one cycle
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              enc_valid_i,
  output logic              enc_ready_o,
  input  logic              enc_last_i,
  input  logic [4:0]        mnem_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic [31:0]       csum_o,
  output logic              done_o,
  output logic              err_illegal_o,
  output logic              err_ovf_o
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  state_e            state_q, state_d;
  logic              we_q, we_d, done_q, done_d;
  logic              ill_q, ill_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ptr_q, ptr_d;
  logic [31:0]       data_q, data_d, csum_q, csum_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [31:0]       word;
  logic              legal;
  logic [ADDR_W+1:0] fill;
  logic              full, xfer;

  instr_field_packer u_packer (
    .mnem_i   (mnem_i),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .rd_i     (rd_i),
    .imm_i    (imm_i),
    .target_i (target_i),
    .word_o   (word),
    .legal_o  (legal)
  );

  // A write still in flight already owns a slot, so it counts toward capacity
  assign fill        = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, we_q};
  assign full        = (fill >= DEPTH_W);
  assign enc_ready_o = (state_q == ST_LOAD) && !full;
  assign xfer        = enc_valid_i && enc_ready_o;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    csum_d  = csum_q;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
    if (we_q) begin
      ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      csum_d  = csum_q ^ data_q;
    end
    case (state_q)
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (start_i) begin
          // Restart also drops any pending write from the abandoned session
          state_d = ST_LOAD;
          ptr_d   = BASE;
          count_d = '0;
          csum_d  = '0;
          ill_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (state_q == ST_LOAD) begin
          if (xfer) begin
            if (legal) begin
              we_d   = 1'b1;
              addr_d = ptr_q + {{(ADDR_W-1){1'b0}}, we_q};
              data_d = word;
            end else begin
              ill_d = 1'b1;
            end
            if (enc_last_i) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else if (enc_valid_i && full) begin
            ovf_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= BASE;
      count_q <= '0;
      csum_q  <= '0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
    end
  end

  assign imem_we_o     = we_q;
  assign imem_addr_o   = addr_q;
  assign imem_data_o   = data_q;
  assign count_o       = count_q;
  assign csum_o        = csum_q;
  assign done_o        = done_q;
  assign err_illegal_o = ill_q;
  assign err_ovf_o     = ovf_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: directed literal scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of sessions and writes.
module tb_instr_stream_encoder;

  localparam int AW    = 8;
  localparam int BASE  = 8;
  localparam int DEPTH = 6;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0, enc_valid_i = 1'b0, enc_last_i = 1'b0;
  logic          enc_ready_o;
  logic [4:0]    mnem_i = '0, rs_i = '0, rt_i = '0, rd_i = '0;
  logic [15:0]   imm_i = '0;
  logic [25:0]   target_i = '0;
  logic          imem_we_o, done_o, err_illegal_o, err_ovf_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_data_o, csum_o;
  logic [AW:0]   count_o;

  instr_stream_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .enc_valid_i(enc_valid_i),
    .enc_ready_o(enc_ready_o), .enc_last_i(enc_last_i), .mnem_i(mnem_i), .rs_i(rs_i),
    .rt_i(rt_i), .rd_i(rd_i), .imm_i(imm_i), .target_i(target_i), .imem_we_o(imem_we_o),
    .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o), .count_o(count_o), .csum_o(csum_o),
    .done_o(done_o), .err_illegal_o(err_illegal_o), .err_ovf_o(err_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference encoder from the mnemonic table; bit 32 = legal
  function automatic logic [32:0] ref_enc(input int m, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [15:0] imm,
                                          input logic [25:0] tgt);
    int fn[5] = '{32, 34, 36, 37, 42};
    int op[12] = '{8, 10, 13, 15, 35, 43, 4, 5, 6, 1, 2, 3};
    logic [5:0] o;
    if (m <= 4) return {1'b1, 6'd0, rs, rt, rd, 5'd0, 6'(fn[m])};
    if (m == 5) return {1'b1, 6'd0, rs, 5'd0, 5'd0, 5'd0, 6'd8};
    if (m > 17) return 33'd0;
    o = 6'(op[m-6]);
    if (m >= 16) return {1'b1, o, tgt};
    if (m == 9)  return {1'b1, o, 5'd0, rt, imm};
    if (m == 15) return {1'b1, o, rs, 5'd1, imm};
    return {1'b1, o, rs, rt, imm};
  endfunction

  // Session model: phase 0 idle, 1 loading, 2 ending
  int          phase = 0, acc = 0, written = 0;
  logic [31:0] m_csum = '0;
  bit          m_ill = 0, m_ovf = 0, pend = 0, pend_done = 0;
  int          pend_a = 0;
  logic [31:0] pend_d = '0;
  logic [31:0] seen_d[$];
  int          seen_a[$];

  always @(negedge clk_i) begin
    logic [32:0] e;
    bit exp_ready;
    if (!rst_i) begin
      phase = 0; acc = 0; written = 0; m_csum = '0;
      m_ill = 0; m_ovf = 0; pend = 0; pend_done = 0;
    end else begin
      exp_ready = (phase == 1) && (acc < DEPTH);
      chk("we", 64'(imem_we_o), 64'(pend));
      if (pend) begin
        chk("addr", 64'(imem_addr_o), 64'(pend_a));
        chk("data", 64'(imem_data_o), 64'(pend_d));
      end
      if (imem_we_o) begin
        seen_d.push_back(imem_data_o);
        seen_a.push_back(int'(imem_addr_o));
      end
      chk("done", 64'(done_o), 64'(pend_done));
      chk("ready", 64'(enc_ready_o), 64'(exp_ready));
      chk("count", 64'(count_o), 64'(written));
      chk("csum", 64'(csum_o), 64'(m_csum));
      chk("err_illegal", 64'(err_illegal_o), 64'(m_ill));
      chk("err_ovf", 64'(err_ovf_o), 64'(m_ovf));
      if (pend) begin
        written++;
        m_csum ^= pend_d;
      end
      pend = 0;
      pend_done = 0;
      if (phase == 2) begin
        phase = 0;
      end else if (start_i) begin
        phase = 1; acc = 0; written = 0; m_csum = '0; m_ill = 0; m_ovf = 0;
      end else if (phase == 1) begin
        if (enc_valid_i && exp_ready) begin
          e = ref_enc(int'(mnem_i), rs_i, rt_i, rd_i, imm_i, target_i);
          if (e[32]) begin
            pend = 1; pend_a = BASE + acc; pend_d = e[31:0]; acc++;
          end else begin
            m_ill = 1;
          end
          if (enc_last_i) begin
            phase = 2; pend_done = 1;
          end
        end else if (enc_valid_i) begin
          m_ovf = 1;
        end
      end
    end
  end

  // All driver tasks start and end at 1 time unit after a rising edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
  endtask

  task automatic send(input int m, input int rs, input int rt, input int rd, input int imm,
                      input int tgt, input bit last);
    bit ok = 0;
    enc_valid_i = 1'b1; mnem_i = m[4:0]; rs_i = rs[4:0]; rt_i = rt[4:0]; rd_i = rd[4:0];
    imm_i = imm[15:0]; target_i = tgt[25:0]; enc_last_i = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      ok = enc_ready_o;
      cyc(1);
    end
    enc_valid_i = 1'b0;
    enc_last_i  = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout actual=no_handshake required=handshake mnem=%0d", m);
    end
  endtask

  task automatic chk_seen(input string name, input int idx, input int a, input logic [31:0] d);
    if (idx >= seen_d.size()) begin
      total++; bad++;
      $display("FAIL %s actual=missing_write required=write_%0d", name, idx);
    end else begin
      chk({name, "_addr"}, 64'(seen_a[idx]), 64'(a));
      chk({name, "_data"}, 64'(seen_d[idx]), 64'(d));
    end
  endtask

  initial begin
    int k;
    bit hs;
    int r;
    #12;
    chk("rst_we", 64'(imem_we_o), 64'd0);
    chk("rst_ready", 64'(enc_ready_o), 64'd0);
    chk("rst_outs", {count_o, csum_o, done_o, err_illegal_o, err_ovf_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cyc(2);

    // ADDI, then ADD/J/JAL back-to-back ending the session
    pulse_start();
    k = seen_d.size();
    send(6, 1, 2, 0, 5, 0, 0);
    cyc(2);
    chk_seen("addi", k, BASE, 32'h20220005);
    send(0, 1, 2, 3, 0, 0, 0);
    send(16, 0, 0, 0, 0, 'h40, 0);
    send(17, 0, 0, 0, 0, 'h100, 1);
    cyc(3);
    chk_seen("add", k + 1, BASE + 1, 32'h00221820);
    chk_seen("j", k + 2, BASE + 2, 32'h08000040);
    chk_seen("jal", k + 3, BASE + 3, 32'h0C000100);
    chk("s1_count", 64'(count_o), 64'd4);
    chk("s1_csum", 64'(csum_o), 64'h24001965);

    // BGEZ as the only and final instruction
    pulse_start();
    send(15, 4, 9, 0, 'hFFFE, 0, 1);
    chk("bgez_done", 64'(done_o), 64'd1);
    chk("bgez_we", 64'(imem_we_o), 64'd1);
    chk("bgez_data", 64'(imem_data_o), 64'h0481FFFE);
    cyc(1);
    chk("bgez_done_end", 64'(done_o), 64'd0);
    chk("bgez_count", 64'(count_o), 64'd1);
    cyc(2);

    // Unknown mnemonic: no write, sticky flag, next word reuses the address
    pulse_start();
    k = seen_d.size();
    send(31, 1, 2, 3, 0, 0, 0);
    send(0, 1, 2, 3, 0, 0, 1);
    cyc(3);
    chk("ill_flag", 64'(err_illegal_o), 64'd1);
    chk("ill_writes", 64'(seen_d.size() - k), 64'd1);
    chk_seen("after_ill", k, BASE, 32'h00221820);

    // Fill to DEPTH, then hold valid while full
    pulse_start();
    k = seen_d.size();
    for (int i = 0; i < DEPTH; i++) send(6, i, i + 1, 0, i, 0, 0);
    enc_valid_i = 1'b1; mnem_i = 5'd0;
    cyc(4);
    enc_valid_i = 1'b0;
    cyc(1);
    chk("ovf_flag", 64'(err_ovf_o), 64'd1);
    chk("ovf_count", 64'(count_o), 64'(DEPTH));
    chk("ovf_writes", 64'(seen_d.size() - k), 64'(DEPTH));
    pulse_start();
    chk("restart_ovf", 64'(err_ovf_o), 64'd0);
    chk("restart_ready", 64'(enc_ready_o), 64'd1);

    // Randomized traffic; the model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      hs = enc_valid_i && enc_ready_o;
      cyc(1);
      start_i = ($urandom_range(0, 39) == 0);
      if (!enc_valid_i || hs) begin
        r = int'($urandom_range(0, 19));
        enc_valid_i = ($urandom_range(0, 2) != 0);
        mnem_i   = (r == 19) ? 5'd31 : 5'(r);
        rs_i     = 5'($urandom); rt_i = 5'($urandom); rd_i = 5'($urandom);
        imm_i    = 16'($urandom); target_i = 26'($urandom);
        enc_last_i = ($urandom_range(0, 9) == 0);
      end
    end
    start_i = 1'b0; enc_valid_i = 1'b0; enc_last_i = 1'b0;
    cyc(3);

    // Reset asserted during a write cycle
    pulse_start();
    send(0, 5, 6, 7, 0, 0, 0);
    chk("pre_rst_we", 64'(imem_we_o), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_mid_we", 64'(imem_we_o), 64'd0);
    chk("rst_mid_outs", {count_o, csum_o, done_o, err_illegal_o, err_ovf_o, enc_ready_o}, 64'd0);
    cyc(2);
    rst_i = 1'b1;
    cyc(3);
    chk("post_rst_ready", 64'(enc_ready_o), 64'd0);
    pulse_start();
    chk("post_start_ready", 64'(enc_ready_o), 64'd1);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
